// File: rtl/text_pkg.sv
// Shared constants for the text tile renderer: tile geometry, glyph codes
// and the per-row bitmaps of the two letter glyphs.
package text_pkg;

    localparam int TILE_W      = 8;
    localparam int TILE_H      = 16;
    localparam int TILE_W_LOG2 = $clog2(TILE_W);
    localparam int TILE_H_LOG2 = $clog2(TILE_H);

    localparam int CODE_BLANK = 0;
    localparam int CODE_D     = 1;
    localparam int CODE_J     = 2;
    localparam int CODE_SOLID = 3;

    typedef logic [7:0] row_byte_t;

    // Index 0 is the top row of the glyph; bit 7 is the leftmost pixel.
    localparam logic [0:15][7:0] ROWS_D = {
        8'h00, 8'hF8, 8'h6C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66,
        8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h6C, 8'hF8, 8'h00
    };

    localparam logic [0:15][7:0] ROWS_J = {
        8'h00, 8'h1E, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C,
        8'h0C, 8'h0C, 8'h0C, 8'hCC, 8'hCC, 8'hCC, 8'h78, 8'h00
    };

endpackage

// File: rtl/font_rom.sv
// Combinational glyph lookup: (code, row) -> 8-pixel row byte, MSB = leftmost.
module font_rom
    import text_pkg::*;
#(
    parameter int CODE_W = 2
) (
    input  logic [CODE_W-1:0] code,
    input  logic [3:0]        row,
    output row_byte_t         row_byte
);

    always_comb begin
        row_byte = '0;
        case (32'(code))
            CODE_D:     row_byte = ROWS_D[row];
            CODE_J:     row_byte = ROWS_J[row];
            CODE_SOLID: row_byte = 8'hFF;
            default:    row_byte = '0;
        endcase
    end

endmodule

// File: rtl/text_tile_renderer.sv
// Renders a short string of tile glyphs at a programmable tile origin as a
// 2-stage pixel pipeline, with optional frame-based blinking.
module text_tile_renderer
    import text_pkg::*;
#(
    parameter  int N_CHARS    = 4,
    parameter  int CODE_W     = 2,
    parameter  int BLINK_LOG2 = 5,
    localparam int IDX_W      = (N_CHARS > 1) ? $clog2(N_CHARS) : 1
) (
    input  logic              reloj,
    input  logic              resetM,
    input  logic [9:0]        Qh,
    input  logic [9:0]        Qv,
    input  logic              px_valid,
    input  logic [6:0]        org_h,
    input  logic [5:0]        org_v,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [CODE_W-1:0] wr_code,
    input  logic              blink_en,
    output logic              wire_BIT_FUENTE,
    output logic              px_valid_o
);

    logic [CODE_W-1:0]     slots [N_CHARS];
    logic [6:0]            m_h;
    logic [5:0]            m_v;
    logic [7:0]            rel_h;
    logic                  hit;
    logic [CODE_W-1:0]     code_rd;
    logic                  at_origin;
    logic                  origin_d;
    logic                  frame_tick;
    logic [BLINK_LOG2-1:0] frame_cnt;
    logic                  visible;

    logic                  s1_hit;
    logic                  s1_valid;
    logic [CODE_W-1:0]     s1_code;
    logic [3:0]            s1_row;
    logic [2:0]            s1_col;
    row_byte_t             s1_row_byte;

    assign m_h   = Qh[9:TILE_W_LOG2];
    assign m_v   = Qv[9:TILE_H_LOG2];
    // 8-bit difference: columns left of the origin come out >= 128 and miss.
    assign rel_h = {1'b0, m_h} - {1'b0, org_h};
    assign hit   = (m_v == org_v) && (m_h >= org_h) && (rel_h < 8'(N_CHARS));

    always_comb begin
        code_rd = '0;
        for (int i = 0; i < N_CHARS; i++) begin
            if (rel_h == 8'(i)) code_rd = slots[i];
        end
    end

    assign at_origin  = (Qh == '0) && (Qv == '0);
    assign frame_tick = at_origin && !origin_d;
    assign visible    = !blink_en || !frame_cnt[BLINK_LOG2-1];

    // NOTE: the slot table is a small register file, not a RAM, so it is safe
    // and required to clear every entry on reset.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            for (int i = 0; i < N_CHARS; i++) slots[i] <= '0;
        end else if (wr_en && (32'(wr_idx) < N_CHARS)) begin
            slots[wr_idx] <= wr_code;
        end
    end

    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            origin_d  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            origin_d <= at_origin;
            if (frame_tick) frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // NOTE: non-blocking assignments make stage 1 see the pre-write slot value
    // when a write and a lookup hit the same slot on one edge.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            s1_hit   <= 1'b0;
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_row   <= '0;
            s1_col   <= '0;
        end else begin
            s1_hit   <= px_valid && hit && visible;
            s1_valid <= px_valid;
            s1_code  <= code_rd;
            s1_row   <= Qv[TILE_H_LOG2-1:0];
            s1_col   <= Qh[TILE_W_LOG2-1:0];
        end
    end

    font_rom #(.CODE_W(CODE_W)) u_font_rom (
        .code     (s1_code),
        .row      (s1_row),
        .row_byte (s1_row_byte)
    );

    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            wire_BIT_FUENTE <= 1'b0;
            px_valid_o      <= 1'b0;
        end else begin
            wire_BIT_FUENTE <= s1_hit && s1_row_byte[3'd7 - s1_col];
            px_valid_o      <= s1_valid;
        end
    end

endmodule

// File: tb/tb_text_tile_renderer.sv
// Directed bench for text_tile_renderer: rendering, edges, write hazard,
// blinking and mid-line reset, with hand-computed expected pixels.
module tb_text_tile_renderer;

    localparam int N_CHARS    = 4;
    localparam int CODE_W     = 2;
    localparam int BLINK_LOG2 = 2;
    localparam int IDX_W      = 2;

    logic              reloj = 1'b0;
    logic              resetM;
    logic [9:0]        Qh, Qv;
    logic              px_valid;
    logic [6:0]        org_h;
    logic [5:0]        org_v;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [CODE_W-1:0] wr_code;
    logic              blink_en;
    logic              wire_BIT_FUENTE;
    logic              px_valid_o;

    int total = 0;
    int bad   = 0;

    text_tile_renderer #(
        .N_CHARS    (N_CHARS),
        .CODE_W     (CODE_W),
        .BLINK_LOG2 (BLINK_LOG2)
    ) dut (
        .reloj           (reloj),
        .resetM          (resetM),
        .Qh              (Qh),
        .Qv              (Qv),
        .px_valid        (px_valid),
        .org_h           (org_h),
        .org_v           (org_v),
        .wr_en           (wr_en),
        .wr_idx          (wr_idx),
        .wr_code         (wr_code),
        .blink_en        (blink_en),
        .wire_BIT_FUENTE (wire_BIT_FUENTE),
        .px_valid_o      (px_valid_o)
    );

    always #5 reloj = ~reloj;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge reloj);
        @(negedge reloj);
    endtask

    task automatic drive(input int h, input int v, input logic valid);
        Qh       = 10'(h);
        Qv       = 10'(v);
        px_valid = valid;
    endtask

    task automatic idle();
        drive(1023, 1023, 1'b0);
    endtask

    task automatic write_slot(input int idx, input int code);
        wr_en   = 1'b1;
        wr_idx  = IDX_W'(idx);
        wr_code = CODE_W'(code);
        cyc();
        wr_en   = 1'b0;
    endtask

    // Streams 8 consecutive pixels from (h0, v); pixel j is checked after the
    // second edge following the cycle it was driven in.
    task automatic scan(input string tag, input int h0, input int v,
                        input logic valid, input logic [7:0] exp_bits);
        for (int i = 0; i < 9; i++) begin
            if (i < 8) drive(h0 + i, v, valid);
            else       idle();
            cyc();
            if (i >= 1) begin
                check($sformatf("%s_bit[%0d]", tag, i - 1), 32'(wire_BIT_FUENTE),
                      32'(exp_bits[8 - i]));
                check($sformatf("%s_vld[%0d]", tag, i - 1), 32'(px_valid_o), 32'(valid));
            end
        end
        idle();
    endtask

    task automatic frame_hold(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 1'b0);
            cyc();
        end
        idle();
        cyc();
    endtask

    initial begin
        resetM   = 1'b1;
        wr_en    = 1'b0;
        wr_idx   = '0;
        wr_code  = '0;
        blink_en = 1'b0;
        org_h    = 7'd50;
        org_v    = 6'd16;
        idle();

        #22;
        check("rst_bit", 32'(wire_BIT_FUENTE), 32'd0);
        check("rst_vld", 32'(px_valid_o), 32'd0);
        @(negedge reloj);
        resetM = 1'b0;
        cyc();
        check("rel_bit", 32'(wire_BIT_FUENTE), 32'd0);
        check("rel_vld", 32'(px_valid_o), 32'd0);

        // String {D, D, J, blank} at tile (50, 16).
        write_slot(0, 1);
        write_slot(1, 1);
        write_slot(2, 2);
        write_slot(3, 0);

        scan("d_row1",      400, 257, 1'b1, 8'hF8);
        scan("d2_row3",     408, 259, 1'b1, 8'h66);
        scan("j_row3",      416, 259, 1'b1, 8'h0C);
        scan("blank_slot3", 424, 259, 1'b1, 8'h00);
        scan("outside",     432, 259, 1'b1, 8'h00);
        scan("left_miss",   392, 257, 1'b1, 8'h00);
        scan("no_valid",    400, 257, 1'b0, 8'h00);
        scan("row_miss",    400, 273, 1'b1, 8'h00);

        // Right-edge origin: only tiles 126 and 127 hit, no wrap to 0..1.
        for (int i = 0; i < N_CHARS; i++) write_slot(i, 3);
        org_h = 7'd126;
        scan("edge126",  1008, 257, 1'b1, 8'hFF);
        scan("edge127",  1016, 257, 1'b1, 8'hFF);
        scan("nowrap0",     0, 257, 1'b1, 8'h00);
        scan("nowrap1",     8, 257, 1'b1, 8'h00);
        scan("edge125",  1000, 257, 1'b1, 8'h00);

        // Same-edge write and lookup of slot 0: D row 1 col 5 is 0, solid is 1.
        org_h = 7'd50;
        write_slot(0, 1);
        drive(405, 257, 1'b1);
        wr_en   = 1'b1;
        wr_idx  = 2'd0;
        wr_code = 2'd3;
        cyc();
        wr_en = 1'b0;
        drive(405, 257, 1'b1);
        cyc();
        check("hazard_old", 32'(wire_BIT_FUENTE), 32'd0);
        idle();
        cyc();
        check("hazard_new", 32'(wire_BIT_FUENTE), 32'd1);

        // Blink: counter 0,1 visible; 2,3 hidden; slot 0 is now solid.
        blink_en = 1'b1;
        scan("blink_c0", 400, 257, 1'b1, 8'hFF);
        frame_hold(10);
        scan("blink_c1", 400, 257, 1'b1, 8'hFF);
        frame_hold(1);
        scan("blink_c2", 400, 257, 1'b1, 8'h00);
        frame_hold(2);
        scan("blink_c3", 400, 257, 1'b1, 8'h00);
        blink_en = 1'b0;
        scan("blink_off", 400, 257, 1'b1, 8'hFF);
        blink_en = 1'b1;
        frame_hold(1);
        scan("blink_wrap", 400, 257, 1'b1, 8'hFF);
        blink_en = 1'b0;

        // Mid-string reset: output drops at once, pipeline and slots are cleared.
        drive(400, 257, 1'b1);
        cyc();
        cyc();
        check("pre_rst_bit", 32'(wire_BIT_FUENTE), 32'd1);
        resetM = 1'b1;
        #1;
        check("mid_rst_bit", 32'(wire_BIT_FUENTE), 32'd0);
        check("mid_rst_vld", 32'(px_valid_o), 32'd0);
        @(negedge reloj);
        idle();
        resetM = 1'b0;
        cyc();
        check("post_rst1_bit", 32'(wire_BIT_FUENTE), 32'd0);
        check("post_rst1_vld", 32'(px_valid_o), 32'd0);
        cyc();
        check("post_rst2_bit", 32'(wire_BIT_FUENTE), 32'd0);
        check("post_rst2_vld", 32'(px_valid_o), 32'd0);
        scan("cleared_s0", 400, 257, 1'b1, 8'h00);
        scan("cleared_s1", 408, 257, 1'b1, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
